// File: rtl/q_sim_pkg.sv
// rtl/q_sim_pkg.sv - shared state encoding and default datapath width for the qubit pair sequencer
package q_sim_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_ADD,
    ST_SUB,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/q1_pair_addr.sv
// rtl/q1_pair_addr.sv - maps pair index p to the two amplitude addresses differing only in the target bit
module q1_pair_addr #(
  parameter int N_QUBITS = 4,
  parameter int TW       = $clog2(N_QUBITS) + 1
) (
  input  logic [N_QUBITS-1:0] p,
  input  logic [TW-1:0]       target,
  output logic [N_QUBITS-1:0] i0,
  output logic [N_QUBITS-1:0] i1
);

  logic [N_QUBITS-1:0] w_bit;
  logic [N_QUBITS-1:0] w_mask;

  // Bits below the target stay in place; bits at/above it move up one to open a zero slot.
  assign w_bit  = N_QUBITS'(1) << target;
  assign w_mask = w_bit - N_QUBITS'(1);
  assign i0     = ((p & ~w_mask) << 1) | (p & w_mask);
  assign i1     = i0 | w_bit;

endmodule

// File: rtl/q1_pair_seq.sv
// rtl/q1_pair_seq.sv - single-qubit pair sweep: read amplitude pair, form sum/difference on the CAU, write back
module q1_pair_seq
  import q_sim_pkg::*;
#(
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  N_QUBITS = 4,
  localparam int TW       = $clog2(N_QUBITS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TW-1:0]       target,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ovf,
  output logic                rd_en,
  output logic [N_QUBITS-1:0] rd_addr0,
  output logic [N_QUBITS-1:0] rd_addr1,
  input  logic [DATA_W-1:0]   rd_r [1:0],
  input  logic [DATA_W-1:0]   rd_i [1:0],
  output logic                wr_en,
  output logic [N_QUBITS-1:0] wr_addr0,
  output logic [N_QUBITS-1:0] wr_addr1,
  output logic [DATA_W-1:0]   wr_r [1:0],
  output logic [DATA_W-1:0]   wr_i [1:0],
  output logic [DATA_W-1:0]   cau_A_r [1:0],
  output logic [DATA_W-1:0]   cau_A_i [1:0],
  output logic [DATA_W-1:0]   cau_B_r [1:0],
  output logic [DATA_W-1:0]   cau_B_i [1:0],
  output logic                cau_sum,
  output logic                cau_abs,
  output logic                cau_sel,
  output logic                cau_w_en,
  input  logic [DATA_W-1:0]   cau_S_r [1:0],
  input  logic [DATA_W-1:0]   cau_S_i [1:0],
  input  logic                cau_overflow
);

  localparam logic [TW-1:0]       LP_NQ   = TW'(N_QUBITS);
  localparam logic [N_QUBITS-1:0] LP_LAST = N_QUBITS'((1 << (N_QUBITS - 1)) - 1);

  state_t              r_state, w_next;
  logic [N_QUBITS-1:0] r_p;
  logic [TW-1:0]       r_target;
  logic [DATA_W-1:0]   r_a0_r, r_a0_i, r_a1_r, r_a1_i, r_h_r, r_h_i;
  logic                r_err, r_ovf;
  logic [N_QUBITS-1:0] w_i0, w_i1;
  logic                w_unused;

  q1_pair_addr #(.N_QUBITS(N_QUBITS), .TW(TW)) u_addr (
    .p      (r_p),
    .target (r_target),
    .i0     (w_i0),
    .i1     (w_i1)
  );

  // Lane 1 results are never consumed; both lanes carry identical operands.
  assign w_unused = ^{cau_S_r[1], cau_S_i[1]};
  assign err      = r_err;
  assign ovf      = r_ovf;
  assign cau_abs  = 1'b0;
  assign cau_sel  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_p      <= '0;
      r_target <= '0;
      r_a0_r   <= '0;
      r_a0_i   <= '0;
      r_a1_r   <= '0;
      r_a1_i   <= '0;
      r_h_r    <= '0;
      r_h_i    <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (start) begin
          r_ovf    <= 1'b0;
          r_err    <= (target >= LP_NQ);
          r_p      <= '0;
          r_target <= target;
        end
        ST_WAIT: begin
          r_a0_r <= rd_r[0];
          r_a0_i <= rd_i[0];
          r_a1_r <= rd_r[1];
          r_a1_i <= rd_i[1];
        end
        ST_SUB: begin
          // The ADD result issued last cycle is visible now.
          r_h_r <= cau_S_r[0];
          r_h_i <= cau_S_i[0];
        end
        ST_WB: if (r_p != LP_LAST) r_p <= r_p + N_QUBITS'(1);
        default: ;
      endcase
      if ((r_state == ST_ADD || r_state == ST_SUB) && cau_overflow) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = (r_state != ST_IDLE);
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    wr_en    = 1'b0;
    wr_addr0 = '0;
    wr_addr1 = '0;
    cau_sum  = 1'b0;
    cau_w_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wr_r[k]    = '0;
      wr_i[k]    = '0;
      cau_A_r[k] = '0;
      cau_A_i[k] = '0;
      cau_B_r[k] = '0;
      cau_B_i[k] = '0;
    end
    case (r_state)
      ST_IDLE: if (start) w_next = (target >= LP_NQ) ? ST_DONE : ST_READ;
      ST_READ: begin
        rd_en    = 1'b1;
        rd_addr0 = w_i0;
        rd_addr1 = w_i1;
        w_next   = ST_WAIT;
      end
      ST_WAIT: w_next = ST_ADD;
      ST_ADD, ST_SUB: begin
        for (int k = 0; k < 2; k++) begin
          cau_A_r[k] = r_a0_r;
          cau_A_i[k] = r_a0_i;
          cau_B_r[k] = r_a1_r;
          cau_B_i[k] = r_a1_i;
        end
        cau_w_en = 1'b1;
        cau_sum  = (r_state == ST_ADD);
        w_next   = (r_state == ST_ADD) ? ST_SUB : ST_WB;
      end
      ST_WB: begin
        wr_en    = 1'b1;
        wr_addr0 = w_i0;
        wr_addr1 = w_i1;
        wr_r[0]  = r_h_r;
        wr_i[0]  = r_h_i;
        wr_r[1]  = cau_S_r[0];
        wr_i[1]  = cau_S_i[0];
        w_next   = (r_p == LP_LAST) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
